// File: rtl/mspu_pkg.sv
// mspu_pkg: definitions shared by the memory-access stage and its helpers.
//   SIZE_*        encodings of the 2-bit access size (3 is treated as word)
//   state_t       memory-stage FSM states
//   is_misaligned true when an access cannot be served by a single aligned lane
package mspu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// lane_align: purely combinational byte-lane formatting for the memory stage.
//   Store side: st_size/st_addr_lo/st_data -> st_be (byte enables) and
//               st_wdata (store data replicated across every candidate lane).
//   Load side:  ld_size/ld_addr_lo/ld_unsigned/ld_rdata -> ld_data, the
//               selected byte/half/word sign- or zero-extended to 32 bits.
module lane_align
  import mspu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        // addr[0] is ignored here; only the half-word lane matters
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    ld_data = '0;
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h000000, ld_byte}
                                       : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0000, ld_half}
                                       : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline stage after execute. Non-memory ops pass straight to
// write-back with one cycle of latency; loads/stores issue one request on a
// single-outstanding req/ack data bus and stall execute until the ack.
//
// Optional feature (macro MEM_ACCESS_MISALIGN_TRAP_EN): misaligned half/word
// accesses are dropped without a bus request and flagged on 'misaligned'
// for one cycle. Without the macro 'misaligned' is tied low and the unused
// low address bits are ignored.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   run + *_in, alu_result, unsigned_flag, mem_to_reg_in
//                         execute-stage bundle, sampled only while idle
//   stall                 execute must hold its outputs (transaction pending)
//   run_out, wb_data, rd_out, reg_we_out
//                         write-back bundle, run_out pulses once per op
//   misaligned            one-cycle drop indication (feature build only)
//   dmem_req/addr/we/be/wdata, dmem_ack, dmem_rdata
//                         data-memory bus; request fields stable until ack
module mem_access
  import mspu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] alu_result,
  input  logic [1:0]  bytes_in,
  input  logic [31:0] wdata_in,
  input  logic        we_in,
  input  logic        re_in,
  input  logic        mem_to_reg_in,
  input  logic        unsigned_flag,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  output logic        stall,
  output logic        run_out,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        misaligned,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  state_t state, state_next;

  // Transaction context captured at issue time
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_m2r;
  logic [4:0]  lat_rd;
  logic        lat_rwe;

  logic        is_mem;
  logic        trap;
  logic        accept_mem;
  logic        retire_mem;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lane_align u_lane_align (
    .st_size     (bytes_in),
    .st_addr_lo  (alu_result[1:0]),
    .st_data     (wdata_in),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (lat_size),
    .ld_addr_lo  (lat_addr[1:0]),
    .ld_unsigned (lat_unsigned),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_next = state;
    is_mem     = we_in | re_in;
    trap       = 1'b0;
    accept_mem = 1'b0;
    retire_mem = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap = (state == IDLE) && run && is_mem &&
           is_misaligned(bytes_in, alu_result[1:0]);
`endif
    case (state)
      IDLE: begin
        if (run && is_mem && !trap) begin
          accept_mem = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          retire_mem = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign stall     = (state != IDLE);
  // The word address is derived from the latched address so it can never
  // drift from the lane selection used for the load extract.
  assign dmem_addr = {lat_addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_out      <= 1'b0;
      wb_data      <= '0;
      rd_out       <= '0;
      reg_we_out   <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      lat_addr     <= '0;
      lat_size     <= SIZE_BYTE;
      lat_unsigned <= 1'b0;
      lat_m2r      <= 1'b0;
      lat_rd       <= '0;
      lat_rwe      <= 1'b0;
    end else begin
      run_out <= 1'b0;
      if (accept_mem) begin
        lat_addr     <= alu_result;
        lat_size     <= bytes_in;
        lat_unsigned <= unsigned_flag;
        lat_m2r      <= mem_to_reg_in;
        lat_rd       <= rd_in;
        lat_rwe      <= reg_we_in;
        dmem_req     <= 1'b1;
        dmem_we      <= we_in;
        dmem_be      <= st_be;
        dmem_wdata   <= st_wdata;
      end else if (retire_mem) begin
        dmem_req   <= 1'b0;
        run_out    <= 1'b1;
        // dmem_we still holds the issued direction: 0 means a load
        wb_data    <= (!dmem_we && lat_m2r) ? ld_data : lat_addr;
        rd_out     <= lat_rd;
        reg_we_out <= lat_rwe;
      end else if (state == IDLE && run) begin
        // plain ALU op, or a dropped misaligned access
        run_out    <= 1'b1;
        wb_data    <= alu_result;
        rd_out     <= rd_in;
        reg_we_out <= reg_we_in & ~trap;
      end
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= trap;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] alu_result;
  logic [1:0]  bytes_in;
  logic [31:0] wdata_in;
  logic        we_in, re_in, mem_to_reg_in, unsigned_flag;
  logic [4:0]  rd_in;
  logic        reg_we_in;
  logic        stall, run_out;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic        reg_we_out, misaligned;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk(clk), .reset(reset), .run(run), .alu_result(alu_result),
    .bytes_in(bytes_in), .wdata_in(wdata_in), .we_in(we_in), .re_in(re_in),
    .mem_to_reg_in(mem_to_reg_in), .unsigned_flag(unsigned_flag),
    .rd_in(rd_in), .reg_we_in(reg_we_in), .stall(stall), .run_out(run_out),
    .wb_data(wb_data), .rd_out(rd_out), .reg_we_out(reg_we_out),
    .misaligned(misaligned), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-byte view of the access rules
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int unsigned first_lane(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return int'(a);
    if (sz == 2'd1) return int'(a) & 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= first_lane(sz, a) && i < first_lane(sz, a) + nbytes(sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] a,
                                         input logic u, input logic [31:0] r);
    int unsigned n = nbytes(sz);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    logic [31:0] v = (r >> (8*first_lane(sz, a))) & mask;
    if (!u && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic m_misal(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a != 2'd0;
  endfunction

  logic        m_busy, e_run, e_req, e_mis, e_we, e_rwe;
  logic [31:0] e_addr, e_wdata, e_wb;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic [31:0] p_alu;
  logic [1:0]  p_sz;
  logic        p_u, p_m2r, p_load, p_rwe;
  logic [4:0]  p_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; e_run <= 0; e_req <= 0; e_mis <= 0; e_we <= 0; e_rwe <= 0;
      e_addr <= '0; e_wdata <= '0; e_wb <= '0; e_be <= '0; e_rd <= '0;
      p_alu <= '0; p_sz <= '0; p_u <= 0; p_m2r <= 0; p_load <= 0; p_rwe <= 0; p_rd <= '0;
    end else begin
      e_run <= 1'b0;
      e_mis <= 1'b0;
      if (!m_busy) begin
        if (run) begin
          if (!(we_in || re_in)) begin
            e_run <= 1; e_wb <= alu_result; e_rd <= rd_in; e_rwe <= reg_we_in;
          end else if (TRAP_EN && m_misal(bytes_in, alu_result[1:0])) begin
            e_run <= 1; e_mis <= 1; e_wb <= alu_result; e_rd <= rd_in; e_rwe <= 0;
          end else begin
            m_busy  <= 1;
            e_req   <= 1;
            e_addr  <= alu_result & 32'hFFFF_FFFC;
            e_we    <= we_in;
            e_be    <= m_be(bytes_in, alu_result[1:0]);
            e_wdata <= m_wdata(bytes_in, wdata_in);
            p_alu <= alu_result; p_sz <= bytes_in; p_u <= unsigned_flag;
            p_m2r <= mem_to_reg_in; p_load <= !we_in; p_rd <= rd_in; p_rwe <= reg_we_in;
          end
        end
      end else if (dmem_ack) begin
        m_busy <= 0;
        e_req  <= 0;
        e_run  <= 1;
        e_wb   <= (p_load && p_m2r) ? m_load(p_sz, p_alu[1:0], p_u, dmem_rdata) : p_alu;
        e_rd   <= p_rd;
        e_rwe  <= p_rwe;
      end
    end
  end

  // ---------------- compare process
  always @(negedge clk) begin
    chk("stall", stall, m_busy);
    chk("run_out", run_out, e_run);
    chk("dmem_req", dmem_req, e_req);
    chk("misaligned", misaligned, e_mis);
    if (e_req) begin
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_we", dmem_we, e_we);
      chk("dmem_be", dmem_be, e_be);
      chk("dmem_wdata", dmem_wdata, e_wdata);
    end
    if (e_run) begin
      chk("wb_data", wb_data, e_wb);
      chk("rd_out", rd_out, e_rd);
      chk("reg_we_out", reg_we_out, e_rwe);
    end
  end

  // ---------------- bus responder
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  bit          rd_fixed = 1'b1;
  logic [31:0] fixed_rdata = '0;
  bit          stale_ack = 1'b0;
  bit          stale_rand = 1'b0;

  initial begin
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_rdata = rd_fixed ? fixed_rdata : $urandom;
      if (dmem_req && !reset) begin
        if (wcnt >= ack_delay) begin
          dmem_ack = 1'b1;
          wcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        dmem_ack = stale_ack || (stale_rand && ($urandom_range(0, 3) == 0));
        wcnt = 0;
      end
    end
  end

  // ---------------- driver
  int unsigned req_cycles;
  bit          snap_valid;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;

  task automatic set_op(input bit r, input bit w, input bit l, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input bit m2r,
                        input bit u, input logic [4:0] rd, input bit rwe);
    run = r; we_in = w; re_in = l; bytes_in = sz; alu_result = a; wdata_in = d;
    mem_to_reg_in = m2r; unsigned_flag = u; rd_in = rd; reg_we_in = rwe;
  endtask

  // Inputs are already presented; hold them until the op retires (bounded).
  task automatic run_op();
    int unsigned n = 0;
    req_cycles = 0;
    snap_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (dmem_req) begin
        req_cycles++;
        if (!snap_valid) begin
          snap_valid = 1'b1;
          snap_addr = dmem_addr; snap_be = dmem_be; snap_wdata = dmem_wdata; snap_we = dmem_we;
        end
      end
    end while (m_busy && n < 64);
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL op_timeout: no retire after %0d cycles at %0t", n, $time);
    end
    run = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_op(0, 0, 0, 2'd0, '0, '0, 0, 0, 5'd0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_run_out", run_out, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_reg_we_out", reg_we_out, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_misaligned", misaligned, 0);
    reset = 1'b0;
    @(negedge clk);

    // ALU op
    set_op(1, 0, 0, 2'd2, 32'h1234, '0, 0, 0, 5'd5, 1);
    run_op();
    chk("alu_run_out", run_out, 1);
    chk("alu_wb", wb_data, 32'h1234);
    chk("alu_rd", rd_out, 5);
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", stall, 0);
    chk("alu_model_wb", e_wb, 32'h1234);

    // word store, ack after three request cycles
    ack_delay = 2;
    set_op(1, 1, 0, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, 5'd3, 0);
    run_op();
    chk("sw_addr", snap_addr, 32'h100);
    chk("sw_be", snap_be, 4'b1111);
    chk("sw_wdata", snap_wdata, 32'hDEADBEEF);
    chk("sw_we", snap_we, 1);
    chk("sw_req_cycles", req_cycles, 3);
    chk("sw_run_out", run_out, 1);
    chk("sw_wb", wb_data, 32'h100);

    // signed / unsigned byte loads, ack in first wait cycle
    ack_delay = 0;
    fixed_rdata = 32'h80FF_0000;
    set_op(1, 0, 1, 2'd0, 32'h203, '0, 1, 0, 5'd9, 1);
    run_op();
    chk("lb_wb", wb_data, 32'hFFFF_FF80);
    chk("lb_model_wb", e_wb, 32'hFFFF_FF80);
    chk("lb_req_cycles", req_cycles, 1);
    set_op(1, 0, 1, 2'd0, 32'h203, '0, 1, 1, 5'd9, 1);
    run_op();
    chk("lbu_wb", wb_data, 32'h0000_0080);
    chk("lbu_model_wb", e_wb, 32'h0000_0080);

    // half store / half load at offset 2
    set_op(1, 1, 0, 2'd1, 32'h2, 32'h0000_ABCD, 0, 0, 5'd0, 0);
    run_op();
    chk("sh_be", snap_be, 4'b1100);
    chk("sh_wdata", snap_wdata, 32'hABCD_ABCD);
    chk("sh_model_be", e_be, 4'b1100);
    fixed_rdata = 32'h7FFF_0000;
    set_op(1, 0, 1, 2'd1, 32'h2, '0, 1, 0, 5'd4, 1);
    run_op();
    chk("lh_wb", wb_data, 32'h0000_7FFF);

    // reset while a store is waiting for its ack
    ack_delay = 20;
    set_op(1, 1, 0, 2'd2, 32'h400, 32'h1111_2222, 0, 0, 5'd1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rw_stall_before", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req_async", dmem_req, 0);
    chk("rw_stall_async", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    ack_delay = 0;
    stale_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stale_ack = 1'b0;
    chk("stale_run_out", run_out, 0);
    chk("stale_stall", stall, 0);
    set_op(1, 0, 0, 2'd0, 32'h55AA, '0, 0, 0, 5'd7, 1);
    run_op();
    chk("post_rst_wb", wb_data, 32'h55AA);
    chk("post_rst_rd", rd_out, 7);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    set_op(1, 0, 1, 2'd2, 32'h101, '0, 1, 0, 5'd6, 1);
    run_op();
    chk("mis_flag", misaligned, 1);
    chk("mis_run_out", run_out, 1);
    chk("mis_reg_we", reg_we_out, 0);
    chk("mis_req", dmem_req, 0);
    chk("mis_req_cycles", req_cycles, 0);
    @(negedge clk);
    chk("mis_pulse_end", misaligned, 0);
`endif

    // randomized traffic
    rd_fixed = 1'b0;
    stale_rand = 1'b1;
    repeat (3000) begin
      set_op(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), 2'($urandom), $urandom, $urandom,
             1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      ack_delay = $urandom_range(0, 3);
      run_op();
    end
    stale_rand = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
